// File: rtl/pipeline_pkg.sv
// Shared widths, control-bit positions, FSM encoding and MEM/WB payload for the memory stage.
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 3;

  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              regwrite;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  writereg;
  } memwb_t;

  function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface memory_stage_if;

  logic                             dmem_req;
  logic                             dmem_we;
  logic [pipeline_pkg::DATA_W-1:0]  dmem_addr;
  logic [pipeline_pkg::DATA_W-1:0]  dmem_wdata;
  logic                             dmem_ack;
  logic [pipeline_pkg::DATA_W-1:0]  dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; a bubble kills the write enable and holds the data fields.
module mem_wb_register
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_bubble,
  input  memwb_t i_d,
  output memwb_t o_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_q <= '0;
    end else if (i_bubble) begin
      o_q.regwrite <= 1'b0;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: runs the req/ack data-memory access, stalls upstream while it is outstanding
// and feeds the MEM/WB register.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrls_m,
  input  logic [DATA_W-1:0] aluout_m,
  input  logic [DATA_W-1:0] writedata_m,
  input  logic [REG_W-1:0]  writereg_m,
  memory_stage_if.master    dmem,
  output logic              stall_m,
  output logic              regwrite_w,
  output logic [DATA_W-1:0] result_w,
  output logic [REG_W-1:0]  writereg_w,
  output logic              mem_err
);

  localparam int unsigned   CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic              w_access;
  logic              w_is_store;
  logic              w_start;
  logic              w_misalign;
  logic              w_ack_done;
  logic              w_timeout;

  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_cur;
  logic              r_mem_err;

  memwb_t            w_memwb_d;
  memwb_t            w_memwb_q;

  assign w_access   = ctrls_m[CTRL_MEMTOREG] | ctrls_m[CTRL_MEMWRITE];
  assign w_is_store = ctrls_m[CTRL_MEMWRITE];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_misalign  = 1'b0;
    w_ack_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (is_word_aligned(aluout_m)) begin
            w_state_nxt = BUSY;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = DONE;
            w_misalign  = 1'b1;
          end
        end
      end
      BUSY: begin
        // An ack on the final wait cycle still completes normally.
        if (dmem.dmem_ack) begin
          w_state_nxt = DONE;
          w_ack_done  = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
          w_timeout   = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus latches, wait counter, load-data latch and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_err_cur <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_req <= (w_state_nxt == BUSY);
      if (w_start) begin
        r_addr  <= aluout_m;
        r_wdata <= writedata_m;
        r_we    <= w_is_store;
        r_cnt   <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_ack_done) begin
        r_rdata <= dmem.dmem_rdata;
      end else if (w_timeout || w_misalign) begin
        r_rdata <= '0;
      end
      if (w_timeout || w_misalign) begin
        r_err_cur <= 1'b1;
        r_mem_err <= 1'b1;
      end else if (r_state == DONE) begin
        r_err_cur <= 1'b0;
      end
    end
  end

  assign stall_m = w_access & (r_state != DONE);

  always_comb begin
    w_memwb_d          = '0;
    w_memwb_d.regwrite = ctrls_m[CTRL_REGWRITE] & ~w_is_store & ~r_err_cur;
    w_memwb_d.result   = (ctrls_m[CTRL_MEMTOREG] & ~w_is_store) ? r_rdata : aluout_m;
    w_memwb_d.writereg = writereg_m;
  end

  mem_wb_register u_mem_wb (
    .clk      (clk),
    .reset    (reset),
    .i_bubble (stall_m),
    .i_d      (w_memwb_d),
    .o_q      (w_memwb_q)
  );

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  assign regwrite_w = w_memwb_q.regwrite;
  assign result_w   = w_memwb_q.result;
  assign writereg_w = w_memwb_q.writereg;
  assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: table of single-cycle ALU ops plus hand sequences for memory accesses.
module tb_memory_stage;
  import pipeline_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        ctrls_m;
  logic [31:0]       aluout_m;
  logic [31:0]       writedata_m;
  logic [4:0]        writereg_m;
  logic              stall_m;
  logic              regwrite_w;
  logic [31:0]       result_w;
  logic [4:0]        writereg_w;
  logic              mem_err;

  int checks = 0;
  int errors = 0;

  memory_stage_if dmem_bus ();

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrls_m     (ctrls_m),
    .aluout_m    (aluout_m),
    .writedata_m (writedata_m),
    .writereg_m  (writereg_m),
    .dmem        (dmem_bus),
    .stall_m     (stall_m),
    .regwrite_w  (regwrite_w),
    .result_w    (result_w),
    .writereg_w  (writereg_w),
    .mem_err     (mem_err)
  );

  typedef struct {
    logic [2:0]  ctrls;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        exp_rw;
    logic [31:0] exp_res;
  } alu_vec_t;

  alu_vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    ctrls_m     = 3'b000;
    aluout_m    = 32'h0;
    writedata_m = 32'h0;
    writereg_m  = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_nop();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",      32'(dmem_bus.dmem_req), 32'h0);
    chk("rst_we",       32'(dmem_bus.dmem_we),  32'h0);
    chk("rst_addr",     dmem_bus.dmem_addr,     32'h0);
    chk("rst_wdata",    dmem_bus.dmem_wdata,    32'h0);
    chk("rst_stall",    32'(stall_m),           32'h0);
    chk("rst_regwrite", 32'(regwrite_w),        32'h0);
    chk("rst_result",   result_w,               32'h0);
    chk("rst_writereg", 32'(writereg_w),        32'h0);
    chk("rst_mem_err",  32'(mem_err),           32'h0);
    reset = 1'b0;
  endtask

  // One non-memory instruction: no stall, no request, written back on the next edge.
  task automatic alu_step(input alu_vec_t v, input int idx);
    ctrls_m    = v.ctrls;
    aluout_m   = v.alu;
    writereg_m = v.wreg;
    #1;
    chk($sformatf("alu%0d_stall", idx), 32'(stall_m), 32'h0);
    chk($sformatf("alu%0d_req", idx),   32'(dmem_bus.dmem_req), 32'h0);
    @(posedge clk);
    #1;
    chk($sformatf("alu%0d_regwrite", idx), 32'(regwrite_w), 32'(v.exp_rw));
    chk($sformatf("alu%0d_result", idx),   result_w,         v.exp_res);
    chk($sformatf("alu%0d_writereg", idx), 32'(writereg_w),  32'(v.wreg));
  endtask

  // One memory instruction held until stall_m drops; the memory acks on BUSY cycle ack_idx (-1 = never).
  task automatic run_mem(input string name, input logic [2:0] ctrls, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] wreg, input int ack_idx,
                         input logic [31:0] rdata, input int exp_stall, input int exp_req,
                         input logic exp_rw, input logic [31:0] exp_res, input logic exp_err);
    int   stalls = 0;
    int   reqs   = 0;
    int   n      = 0;
    logic bus_ok = 1'b1;
    logic bub_ok = 1'b1;
    logic done   = 1'b0;
    ctrls_m     = ctrls;
    aluout_m    = addr;
    writedata_m = wdata;
    writereg_m  = wreg;
    while (!done && n < 40) begin
      if (dmem_bus.dmem_req) begin
        if (dmem_bus.dmem_we !== ctrls[0] || dmem_bus.dmem_addr !== addr ||
            dmem_bus.dmem_wdata !== wdata)
          bus_ok = 1'b0;
        dmem_bus.dmem_ack   = (reqs == ack_idx);
        dmem_bus.dmem_rdata = (reqs == ack_idx) ? rdata : 32'hBAD0_BAD0;
        reqs++;
      end else begin
        dmem_bus.dmem_ack = 1'b0;
      end
      if (n > 0 && regwrite_w !== 1'b0) bub_ok = 1'b0;
      #1;
      if (stall_m) stalls++;
      else         done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    dmem_bus.dmem_ack = 1'b0;
    drive_nop();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_bound: stall_m never released within 40 cycles", name);
    end
    chk({name, "_stall_cycles"}, 32'(stalls),        32'(exp_stall));
    chk({name, "_req_cycles"},   32'(reqs),          32'(exp_req));
    chk({name, "_bus_fields"},   32'(bus_ok),        32'h1);
    chk({name, "_bubble"},       32'(bub_ok),        32'h1);
    chk({name, "_regwrite"},     32'(regwrite_w),    32'(exp_rw));
    chk({name, "_result"},       result_w,           exp_res);
    chk({name, "_writereg"},     32'(writereg_w),    32'(wreg));
    chk({name, "_mem_err"},      32'(mem_err),       32'(exp_err));
    chk({name, "_req_after"},    32'(dmem_bus.dmem_req), 32'h0);
  endtask

  initial begin
    vecs[0] = '{3'b100, 32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234};
    vecs[1] = '{3'b000, 32'hFFFF_0003, 5'd7,  1'b0, 32'hFFFF_0003};
    vecs[2] = '{3'b100, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{3'b100, 32'h0000_0000, 5'd0,  1'b1, 32'h0000_0000};
    vecs[4] = '{3'b000, 32'h0000_0042, 5'd1,  1'b0, 32'h0000_0042};
    vecs[5] = '{3'b100, 32'h0BAD_F00D, 5'd9,  1'b1, 32'h0BAD_F00D};

    do_reset();
    for (int i = 0; i < 6; i++) alu_step(vecs[i], i);

    run_mem("load_ack2",  3'b110, 32'h40, 32'h0, 5'd3, 1, 32'hDEAD_BEEF,
            3, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_mem("store_ack1", 3'b001, 32'h80, 32'hA5A5_A5A5, 5'd4, 0, 32'h0,
            2, 1, 1'b0, 32'h80, 1'b0);
    run_mem("both_bits",  3'b111, 32'hC4, 32'h0F0F_0F0F, 5'd6, 1, 32'h1111_2222,
            3, 2, 1'b0, 32'hC4, 1'b0);
    run_mem("ack_at_last", 3'b110, 32'h100, 32'h0, 5'd8, 15, 32'h1357_9BDF,
            17, 16, 1'b1, 32'h1357_9BDF, 1'b0);
    alu_step(vecs[0], 10);
    run_mem("timeout",    3'b110, 32'h200, 32'h0, 5'd10, -1, 32'h0,
            17, 16, 1'b0, 32'h0, 1'b1);
    alu_step(vecs[5], 11);
    chk("err_sticky", 32'(mem_err), 32'h1);

    do_reset();
    run_mem("misaligned", 3'b110, 32'h42, 32'h0, 5'd12, -1, 32'h0,
            1, 0, 1'b0, 32'h0, 1'b1);
    alu_step(vecs[2], 12);

    // Reset while BUSY, then a stray ack once back in IDLE.
    do_reset();
    ctrls_m    = 3'b110;
    aluout_m   = 32'h300;
    writereg_m = 5'd13;
    @(posedge clk); #1;
    chk("rb_req_busy", 32'(dmem_bus.dmem_req), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    chk("rb_req",      32'(dmem_bus.dmem_req), 32'h0);
    chk("rb_addr",     dmem_bus.dmem_addr,     32'h0);
    chk("rb_stall",    32'(stall_m),           32'h0);
    chk("rb_regwrite", 32'(regwrite_w),        32'h0);
    chk("rb_result",   result_w,               32'h0);
    chk("rb_writereg", 32'(writereg_w),        32'h0);
    chk("rb_mem_err",  32'(mem_err),           32'h0);
    reset = 1'b0;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
    chk("late_ack_req",      32'(dmem_bus.dmem_req), 32'h0);
    chk("late_ack_regwrite", 32'(regwrite_w),        32'h0);
    chk("late_ack_mem_err",  32'(mem_err),           32'h0);
    @(posedge clk); #1;
    chk("late_ack_req2",     32'(dmem_bus.dmem_req), 32'h0);
    chk("late_ack_result",   result_w,               32'h0);
    ctrls_m  = 3'b110;
    aluout_m = 32'h304;
    #1;
    chk("late_ack_idle_stall", 32'(stall_m), 32'h1);
    drive_nop();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
